// File: rtl/calc_ctrl_core.sv
// calc_ctrl_core
//   Control core of a small serial calculator. Two FSMs work together:
//   - A key decoder that watches a serial key stream. After KEY_SEQ it takes
//     one extra bit that selects the operating mode, then latches "active".
//   - A flow sequencer that runs one operation per valid_cmd:
//       direct mode (calc_mode=0): LOAD -> TX
//       memory mode, write:        WRITE
//       memory mode, read:         READ -> LOAD -> TX
//   The result word is packed combinationally from its field inputs.
//
// Handshake: valid_cmd is a level qualifier. It is sampled at every rising
//   edge. There is no ready; a command offered while the flow is not idle is
//   dropped. tx_done is a one-cycle pulse and is honoured only in TX.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   input_key           serial key bit (qualified by valid_cmd)
//   valid_cmd           qualifies input_key and starts flow operations
//   rw                  1=write, 0=read (memory mode only)
//   tx_done             end-of-transmit pulse from the serializer
//   in_a,in_b,alu_out,
//   flag,sel            result-word fields
//   calc_active         key accepted
//   calc_mode           0=direct transmit, 1=memory mode
//   ctrl_ac_mem         memory access enable
//   ctrl_rw_mem         memory direction (1=write)
//   p_load              serializer parallel load
//   tx_dat              transmit enable
//   busy                flow not idle
//   data_out            {in_a, in_b, alu_out, flag, sel}
//   key_state_dbg       key decoder state (0=IDLE,1..4=K1..K4,5=ACTIVE)
//   flow_state_dbg      flow state (0=IDLE,1=WRITE,2=READ,3=LOAD,4=TX)
module calc_ctrl_core #(
  parameter logic [3:0] KEY_SEQ = 4'b1010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_key,
  input  logic        valid_cmd,
  input  logic        rw,
  input  logic        tx_done,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  flag,
  input  logic [3:0]  sel,
  output logic        calc_active,
  output logic        calc_mode,
  output logic        ctrl_ac_mem,
  output logic        ctrl_rw_mem,
  output logic        p_load,
  output logic        tx_dat,
  output logic        busy,
  output logic [31:0] data_out,
  output logic [2:0]  key_state_dbg,
  output logic [2:0]  flow_state_dbg
);

  typedef enum logic [2:0] {
    K_IDLE   = 3'd0,
    K_1      = 3'd1,
    K_2      = 3'd2,
    K_3      = 3'd3,
    K_4      = 3'd4,
    K_ACTIVE = 3'd5
  } key_state_t;

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_WRITE = 3'd1,
    F_READ  = 3'd2,
    F_LOAD  = 3'd3,
    F_TX    = 3'd4
  } flow_state_t;

  key_state_t  key_state, key_next;
  flow_state_t flow_state, flow_next;
  logic        mode_q, mode_next;
  logic        active_int;
  logic        rw_eff;

  assign data_out = {in_a, in_b, alu_out, flag, sel};

  // ---------------- key decoder ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      key_state <= K_IDLE;
      mode_q    <= 1'b0;
    end else begin
      key_state <= key_next;
      mode_q    <= mode_next;
    end
  end

  // On a wrong bit the decoder re-synchronises: if the wrong bit happens to
  // be the first key bit, it already counts as the start of a new attempt.
  always_comb begin
    key_next  = key_state;
    mode_next = mode_q;
    if (valid_cmd) begin
      case (key_state)
        K_IDLE: key_next = (input_key == KEY_SEQ[3]) ? K_1 : K_IDLE;
        K_1: key_next = (input_key == KEY_SEQ[2]) ? K_2 :
                        ((input_key == KEY_SEQ[3]) ? K_1 : K_IDLE);
        K_2: key_next = (input_key == KEY_SEQ[1]) ? K_3 :
                        ((input_key == KEY_SEQ[3]) ? K_1 : K_IDLE);
        K_3: key_next = (input_key == KEY_SEQ[0]) ? K_4 :
                        ((input_key == KEY_SEQ[3]) ? K_1 : K_IDLE);
        K_4: begin
          key_next  = K_ACTIVE;
          mode_next = input_key;
        end
        K_ACTIVE: key_next = K_ACTIVE;  // sticky until reset, mode frozen
        default:  key_next = K_IDLE;
      endcase
    end
  end

  assign active_int = (key_state == K_ACTIVE);
  assign rw_eff     = rw & active_int;

  // ---------------- flow sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) flow_state <= F_IDLE;
    else       flow_state <= flow_next;
  end

  // rw and calc_mode only matter at the IDLE decision, so changing them
  // mid-operation cannot disturb the operation in progress.
  always_comb begin
    flow_next = flow_state;
    case (flow_state)
      F_IDLE: begin
        if (active_int && valid_cmd) begin
          if (!mode_q)     flow_next = F_LOAD;
          else if (rw_eff) flow_next = F_WRITE;
          else             flow_next = F_READ;
        end
      end
      F_WRITE: flow_next = F_IDLE;
      F_READ:  flow_next = F_LOAD;  // memory read data registers during READ
      F_LOAD:  flow_next = F_TX;
      F_TX:    flow_next = tx_done ? F_IDLE : F_TX;
      default: flow_next = F_IDLE;
    endcase
  end

  // Moore outputs. They are gated by reset so that they read 0 for the
  // whole reset cycle, not only after the next edge.
  always_comb begin
    ctrl_ac_mem = 1'b0;
    ctrl_rw_mem = 1'b0;
    p_load      = 1'b0;
    tx_dat      = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      case (flow_state)
        F_WRITE: begin ctrl_ac_mem = 1'b1; ctrl_rw_mem = 1'b1; busy = 1'b1; end
        F_READ:  begin ctrl_ac_mem = 1'b1; busy = 1'b1; end
        F_LOAD:  begin p_load = 1'b1; busy = 1'b1; end
        F_TX:    begin tx_dat = 1'b1; busy = 1'b1; end
        default: ;
      endcase
    end
  end

  assign calc_active    = active_int & ~reset;
  assign calc_mode      = mode_q;
  assign key_state_dbg  = key_state;
  assign flow_state_dbg = flow_state;

endmodule

// File: tb/tb_calc_ctrl_core.sv
module tb_calc_ctrl_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, input_key, valid_cmd, rw, tx_done;
  logic [7:0]  in_a, in_b, alu_out;
  logic [3:0]  flag, sel;
  logic        calc_active, calc_mode, ctrl_ac_mem, ctrl_rw_mem;
  logic        p_load, tx_dat, busy;
  logic [31:0] data_out;
  logic [2:0]  key_state_dbg, flow_state_dbg;

  int total = 0;
  int bad   = 0;

  // {calc_active, ctrl_ac_mem, ctrl_rw_mem, p_load, tx_dat, busy}
  logic [5:0] outs;
  assign outs = {calc_active, ctrl_ac_mem, ctrl_rw_mem, p_load, tx_dat, busy};

  localparam logic [5:0] O_RST   = 6'b000000;
  localparam logic [5:0] O_OFF   = 6'b000000;
  localparam logic [5:0] O_IDLE  = 6'b100000;
  localparam logic [5:0] O_WRITE = 6'b111001;
  localparam logic [5:0] O_READ  = 6'b110001;
  localparam logic [5:0] O_LOAD  = 6'b100101;
  localparam logic [5:0] O_TX    = 6'b100011;

  calc_ctrl_core #(.KEY_SEQ(4'b1010)) dut (
    .clk(clk), .reset(reset), .input_key(input_key), .valid_cmd(valid_cmd),
    .rw(rw), .tx_done(tx_done), .in_a(in_a), .in_b(in_b), .alu_out(alu_out),
    .flag(flag), .sel(sel), .calc_active(calc_active), .calc_mode(calc_mode),
    .ctrl_ac_mem(ctrl_ac_mem), .ctrl_rw_mem(ctrl_rw_mem), .p_load(p_load),
    .tx_dat(tx_dat), .busy(busy), .data_out(data_out),
    .key_state_dbg(key_state_dbg), .flow_state_dbg(flow_state_dbg)
  );

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_cmd = 1'b0; input_key = 1'b0; rw = 1'b0; tx_done = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    valid_cmd = 1'b1;
    input_key = b;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; valid_cmd = 1'b0; input_key = 1'b0; rw = 1'b0; tx_done = 1'b0;
    in_a = 8'h07; in_b = 8'h08; alu_out = 8'h0F; flag = 4'h0; sel = 4'h1;
    step(); step();
    total++;
    if (outs !== O_RST) begin
      $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); bad++;
    end
    total++;
    if (calc_mode !== 1'b0) begin
      $display("FAIL reset_mode got=%b exp=0", calc_mode); bad++;
    end
    total++;
    if (key_state_dbg !== 3'd0 || flow_state_dbg !== 3'd0) begin
      $display("FAIL reset_states got=%0d/%0d exp=0/0", key_state_dbg, flow_state_dbg); bad++;
    end
    total++;
    if (data_out !== 32'h07080F01) begin
      $display("FAIL data_out_in_reset got=%h exp=07080f01", data_out); bad++;
    end
    reset = 1'b0;
    step();
    total++;
    if (outs !== O_OFF) begin
      $display("FAIL post_reset_outs got=%b exp=%b", outs, O_OFF); bad++;
    end
  endtask

  task automatic test_data_out();
    in_a = 8'hA5; in_b = 8'h3C; alu_out = 8'hE1; flag = 4'h9; sel = 4'h6;
    #1;
    total++;
    if (data_out !== 32'hA53CE196) begin
      $display("FAIL data_out_1 got=%h exp=a53ce196", data_out); bad++;
    end
    in_a = 8'h00; in_b = 8'hFF; alu_out = 8'h00; flag = 4'hF; sel = 4'h0;
    #1;
    total++;
    if (data_out !== 32'h00FF00F0) begin
      $display("FAIL data_out_2 got=%h exp=00ff00f0", data_out); bad++;
    end
    in_a = 8'h07; in_b = 8'h08; alu_out = 8'h0F; flag = 4'h0; sel = 4'h1;
    #1;
    total++;
    if (data_out !== 32'h07080F01) begin
      $display("FAIL data_out_3 got=%h exp=07080f01", data_out); bad++;
    end
  endtask

  task automatic test_key_mode1();
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    total++;
    if (calc_active !== 1'b0) begin
      $display("FAIL key1_after4 got=%b exp=0", calc_active); bad++;
    end
    send_bit(1'b1);
    valid_cmd = 1'b0;
    total++;
    if (calc_active !== 1'b1 || calc_mode !== 1'b1) begin
      $display("FAIL key1_active got=%b%b exp=11", calc_active, calc_mode); bad++;
    end
  endtask

  task automatic test_key_mode0();
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    valid_cmd = 1'b0;
    total++;
    if (calc_active !== 1'b1 || calc_mode !== 1'b0) begin
      $display("FAIL key0_active got=%b%b exp=10", calc_active, calc_mode); bad++;
    end
  endtask

  task automatic test_key_resync();
    do_reset();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    total++;
    if (calc_active !== 1'b0) begin
      $display("FAIL resync_early got=%b exp=0", calc_active); bad++;
    end
    send_bit(1'b0);
    valid_cmd = 1'b0;
    total++;
    if (calc_active !== 1'b1 || calc_mode !== 1'b0) begin
      $display("FAIL resync_active got=%b%b exp=10", calc_active, calc_mode); bad++;
    end
    // Idle cycles without valid_cmd must hold the decoder in a partial match.
    do_reset();
    send_bit(1'b1); send_bit(1'b0);
    valid_cmd = 1'b0;
    step(); step(); step();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    valid_cmd = 1'b0;
    total++;
    if (calc_active !== 1'b1 || calc_mode !== 1'b1) begin
      $display("FAIL key_hold got=%b%b exp=11", calc_active, calc_mode); bad++;
    end
    do_reset();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    valid_cmd = 1'b0;
    total++;
    if (calc_active !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL key_zeros got=%b%b exp=00", calc_active, busy); bad++;
    end
  endtask

  task automatic test_write();
    test_key_mode1();
    rw = 1'b1; input_key = 1'b0; valid_cmd = 1'b1;
    step();
    valid_cmd = 1'b0;
    total++;
    if (outs !== O_WRITE) begin
      $display("FAIL write_cycle got=%b exp=%b", outs, O_WRITE); bad++;
    end
    step();
    total++;
    if (outs !== O_IDLE) begin
      $display("FAIL write_idle got=%b exp=%b", outs, O_IDLE); bad++;
    end
    total++;
    if (calc_mode !== 1'b1) begin
      $display("FAIL mode_frozen got=%b exp=1", calc_mode); bad++;
    end
  endtask

  task automatic test_read();
    rw = 1'b0; valid_cmd = 1'b1;
    step();
    valid_cmd = 1'b0;
    rw = 1'b1;  // change mid-operation must not matter
    total++;
    if (outs !== O_READ) begin
      $display("FAIL read_cycle got=%b exp=%b", outs, O_READ); bad++;
    end
    step();
    total++;
    if (outs !== O_LOAD) begin
      $display("FAIL read_load got=%b exp=%b", outs, O_LOAD); bad++;
    end
    tx_done = 1'b1;  // outside TX: ignored
    step();
    tx_done = 1'b0;
    total++;
    if (outs !== O_TX) begin
      $display("FAIL read_tx_enter got=%b exp=%b", outs, O_TX); bad++;
    end
    for (int i = 0; i < 29; i++) begin
      step();
      total++;
      if (outs !== O_TX) begin
        $display("FAIL read_tx_hold[%0d] got=%b exp=%b", i, outs, O_TX); bad++;
      end
    end
    tx_done = 1'b1;
    #1;
    total++;
    if (tx_dat !== 1'b1) begin
      $display("FAIL tx_done_cycle got=%b exp=1", tx_dat); bad++;
    end
    step();
    tx_done = 1'b0;
    total++;
    if (outs !== O_IDLE) begin
      $display("FAIL read_done_idle got=%b exp=%b", outs, O_IDLE); bad++;
    end
    tx_done = 1'b1;  // stray pulse in IDLE
    step();
    tx_done = 1'b0;
    total++;
    if (outs !== O_IDLE) begin
      $display("FAIL stray_tx_done got=%b exp=%b", outs, O_IDLE); bad++;
    end
  endtask

  task automatic test_back_to_back();
    rw = 1'b1; valid_cmd = 1'b1;
    step();
    total++;
    if (outs !== O_WRITE) begin
      $display("FAIL b2b_w1 got=%b exp=%b", outs, O_WRITE); bad++;
    end
    step();
    total++;
    if (outs !== O_IDLE) begin
      $display("FAIL b2b_idle got=%b exp=%b", outs, O_IDLE); bad++;
    end
    step();
    total++;
    if (outs !== O_WRITE) begin
      $display("FAIL b2b_w2 got=%b exp=%b", outs, O_WRITE); bad++;
    end
    valid_cmd = 1'b0;
    step();
    total++;
    if (outs !== O_IDLE) begin
      $display("FAIL b2b_end got=%b exp=%b", outs, O_IDLE); bad++;
    end
  endtask

  task automatic test_reset_mid_tx();
    test_key_mode0();
    rw = 1'b1; valid_cmd = 1'b1;  // rw has no effect in direct mode
    step();
    valid_cmd = 1'b0;
    total++;
    if (outs !== O_LOAD) begin
      $display("FAIL direct_load got=%b exp=%b", outs, O_LOAD); bad++;
    end
    step();
    total++;
    if (outs !== O_TX) begin
      $display("FAIL direct_tx got=%b exp=%b", outs, O_TX); bad++;
    end
    reset = 1'b1;
    #1;
    total++;
    if (outs !== O_RST) begin
      $display("FAIL reset_in_tx got=%b exp=%b", outs, O_RST); bad++;
    end
    step();
    total++;
    if (outs !== O_RST || flow_state_dbg !== 3'd0) begin
      $display("FAIL reset_edge got=%b/%0d exp=%b/0", outs, flow_state_dbg, O_RST); bad++;
    end
    reset = 1'b0;
    step();
    total++;
    if (outs !== O_OFF) begin
      $display("FAIL after_reset got=%b exp=%b", outs, O_OFF); bad++;
    end
    send_bit(1'b1);
    valid_cmd = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || calc_active !== 1'b0) begin
      $display("FAIL no_reactivate got=%b%b exp=00", busy, calc_active); bad++;
    end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    valid_cmd = 1'b0;
    total++;
    if (calc_active !== 1'b1 || calc_mode !== 1'b1) begin
      $display("FAIL reactivate got=%b%b exp=11", calc_active, calc_mode); bad++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_data_out();
    test_key_mode1();
    test_key_mode0();
    test_key_resync();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
